// File: rtl/ball_tracker.sv
// Pong ball tracker: advances the ball one pixel per tick and bounces it off walls and paddles.
// It also scores misses with one-tick PScore/CScore pulses and ends the game at MAX_POINTS.
module ball_tracker #(
  parameter int unsigned Y_MIN       = 175,
  parameter int unsigned Y_MAX       = 426,
  parameter int unsigned X_MIN       = 144,
  parameter int unsigned X_MAX       = 783,
  parameter int unsigned PADDLE_H    = 28,
  parameter int unsigned PADDLE_W    = 4,
  parameter int unsigned BALL_SIZE   = 4,
  parameter int unsigned SERVE_DELAY = 60,
  parameter int unsigned MAX_POINTS  = 9,
  parameter logic [23:0] CENTRE      = 24'h12C1CF
) (
  input  logic        clkB,
  input  logic        Reset,
  input  logic [23:0] PPosition,
  input  logic [23:0] CPosition,
  output logic [23:0] BPosition,
  output logic        PScore,
  output logic        CScore,
  output logic [3:0]  PPoints,
  output logic [3:0]  CPoints,
  output logic        GameOver
);

  localparam int unsigned CW    = 12;
  localparam int unsigned PW    = 4;
  localparam int unsigned CNT_W = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;

  localparam logic [CW-1:0]    Y_MIN_C    = CW'(Y_MIN);
  localparam logic [CW-1:0]    Y_MAX_C    = CW'(Y_MAX);
  localparam logic [CW-1:0]    X_MIN_C    = CW'(X_MIN);
  localparam logic [CW-1:0]    X_MAX_C    = CW'(X_MAX);
  localparam logic [CW-1:0]    PAD_H_C    = CW'(PADDLE_H);
  localparam logic [CW-1:0]    PAD_W_C    = CW'(PADDLE_W);
  localparam logic [CW-1:0]    BALL_C     = CW'(BALL_SIZE);
  localparam logic [CW-1:0]    CENTRE_Y   = CENTRE[23:12];
  localparam logic [CW-1:0]    CENTRE_X   = CENTRE[11:0];
  localparam logic [PW-1:0]    MAX_PTS_C  = PW'(MAX_POINTS);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SERVE_DELAY - 1);

  typedef enum logic [1:0] {
    ST_SERVE,
    ST_MOVE,
    ST_SCORED,
    ST_OVER
  } state_e;

  state_e           state_q;
  logic [CW-1:0]    by_q, bx_q;
  logic             dx_neg_q, dy_neg_q;
  logic [CNT_W-1:0] cnt_q;
  logic             pscore_q, cscore_q;
  logic [PW-1:0]    ppoints_q, cpoints_q;
  logic             game_over_q;

  logic [CW-1:0] ppy_c, ppx_c, cpy_c, cpx_c;
  logic          cmiss_c, pmiss_c;
  logic          p_ovl_c, c_ovl_c;
  logic          dx_neg_c, dy_neg_c;
  logic [CW-1:0] by_nx_c, bx_nx_c;
  logic [PW-1:0] ppoints_inc_c, cpoints_inc_c;

  // One MOVE tick: miss detection, wall/paddle direction flips, then the step itself.
  always_comb begin
    ppy_c = PPosition[23:12];
    ppx_c = PPosition[11:0];
    cpy_c = CPosition[23:12];
    cpx_c = CPosition[11:0];

    cmiss_c = dx_neg_q && (bx_q <= X_MIN_C);
    pmiss_c = !dx_neg_q && ((bx_q + BALL_C) >= X_MAX_C);

    dy_neg_c = dy_neg_q;
    if (dy_neg_q && (by_q <= Y_MIN_C)) begin
      dy_neg_c = 1'b0;
    end else if (!dy_neg_q && ((by_q + BALL_C) >= Y_MAX_C)) begin
      dy_neg_c = 1'b1;
    end

    p_ovl_c = ((by_q + BALL_C) > ppy_c) && (by_q < (ppy_c + PAD_H_C));
    c_ovl_c = ((by_q + BALL_C) > cpy_c) && (by_q < (cpy_c + PAD_H_C));

    dx_neg_c = dx_neg_q;
    if (dx_neg_q && (bx_q == (ppx_c + PAD_W_C)) && p_ovl_c) begin
      dx_neg_c = 1'b0;
    end else if (!dx_neg_q && ((bx_q + BALL_C) == cpx_c) && c_ovl_c) begin
      dx_neg_c = 1'b1;
    end

    by_nx_c = dy_neg_c ? (by_q - CW'(1)) : (by_q + CW'(1));
    bx_nx_c = dx_neg_c ? (bx_q - CW'(1)) : (bx_q + CW'(1));

    ppoints_inc_c = (ppoints_q < MAX_PTS_C) ? (ppoints_q + PW'(1)) : ppoints_q;
    cpoints_inc_c = (cpoints_q < MAX_PTS_C) ? (cpoints_q + PW'(1)) : cpoints_q;
  end

  // Game FSM with all outputs registered.
  always_ff @(posedge clkB) begin
    if (Reset) begin
      state_q     <= ST_SERVE;
      by_q        <= CENTRE_Y;
      bx_q        <= CENTRE_X;
      dx_neg_q    <= 1'b0;
      dy_neg_q    <= 1'b1;
      cnt_q       <= '0;
      pscore_q    <= 1'b0;
      cscore_q    <= 1'b0;
      ppoints_q   <= '0;
      cpoints_q   <= '0;
      game_over_q <= 1'b0;
    end else begin
      case (state_q)
        ST_SERVE: begin
          by_q  <= CENTRE_Y;
          bx_q  <= CENTRE_X;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_q <= ST_MOVE;
          end
        end

        ST_MOVE: begin
          if (cmiss_c) begin
            cscore_q  <= 1'b1;
            cpoints_q <= cpoints_inc_c;
            state_q   <= ST_SCORED;
          end else if (pmiss_c) begin
            pscore_q  <= 1'b1;
            ppoints_q <= ppoints_inc_c;
            state_q   <= ST_SCORED;
          end else begin
            dx_neg_q <= dx_neg_c;
            dy_neg_q <= dy_neg_c;
            by_q     <= by_nx_c;
            bx_q     <= bx_nx_c;
          end
        end

        ST_SCORED: begin
          pscore_q <= 1'b0;
          cscore_q <= 1'b0;
          by_q     <= CENTRE_Y;
          bx_q     <= CENTRE_X;
          cnt_q    <= '0;
          // Serve toward whoever just conceded.
          dx_neg_q <= cscore_q;
          if ((ppoints_q == MAX_PTS_C) || (cpoints_q == MAX_PTS_C)) begin
            game_over_q <= 1'b1;
            state_q     <= ST_OVER;
          end else begin
            state_q <= ST_SERVE;
          end
        end

        ST_OVER: begin
          by_q     <= CENTRE_Y;
          bx_q     <= CENTRE_X;
          pscore_q <= 1'b0;
          cscore_q <= 1'b0;
        end

        default: begin
          state_q <= ST_SERVE;
        end
      endcase
    end
  end

  assign BPosition = {by_q, bx_q};
  assign PScore    = pscore_q;
  assign CScore    = cscore_q;
  assign PPoints   = ppoints_q;
  assign CPoints   = cpoints_q;
  assign GameOver  = game_over_q;

endmodule

// File: tb/tb_ball_tracker.sv
// Scoreboard bench for ball_tracker: stimulus pushes cycle-stamped expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_ball_tracker;

  localparam logic [23:0] C = 24'h12C1CF;

  logic        clkB;
  logic        Reset;
  logic [23:0] PPosition;
  logic [23:0] CPosition;
  logic [23:0] BPosition;
  logic        PScore;
  logic        CScore;
  logic [3:0]  PPoints;
  logic [3:0]  CPoints;
  logic        GameOver;

  ball_tracker dut (
    .clkB      (clkB),
    .Reset     (Reset),
    .PPosition (PPosition),
    .CPosition (CPosition),
    .BPosition (BPosition),
    .PScore    (PScore),
    .CScore    (CScore),
    .PPoints   (PPoints),
    .CPoints   (CPoints),
    .GameOver  (GameOver)
  );

  typedef struct {
    int          cyc;
    string       name;
    logic [23:0] bpos;
    logic        ps;
    logic        cs;
    logic [3:0]  pp;
    logic [3:0]  cp;
    logic        go;
  } exp_t;

  exp_t sb_q[$];
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;

  initial clkB = 1'b0;
  always #5 clkB = ~clkB;

  always @(posedge clkB) cyc <= cyc + 1;

  task automatic expect_at(input int c, input string nm, input logic [23:0] b,
                           input logic ps, input logic cs, input logic [3:0] pp,
                           input logic [3:0] cp, input logic go);
    exp_t e;
    e.cyc = c; e.name = nm; e.bpos = b; e.ps = ps; e.cs = cs;
    e.pp = pp; e.cp = cp; e.go = go;
    sb_q.push_back(e);
  endtask

  // Monitor: compare every expectation that falls due on this cycle.
  always @(negedge clkB) begin
    exp_t e;
    if (PScore || CScore) begin
      tests++;
      if (PScore && CScore) begin
        fails++;
        $display("FAIL pulse_exclusive @cyc %0d: got PScore=1 CScore=1, expected at most one", cyc);
      end
    end
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      e = sb_q.pop_front();
      tests++;
      if (e.cyc != cyc) begin
        fails++;
        $display("FAIL %s: checked late at cyc %0d, expected cyc %0d", e.name, cyc, e.cyc);
      end else if (BPosition !== e.bpos || PScore !== e.ps || CScore !== e.cs ||
                   PPoints !== e.pp || CPoints !== e.cp || GameOver !== e.go) begin
        fails++;
        $display("FAIL %s @cyc %0d: got bpos=%h ps=%b cs=%b pp=%0d cp=%0d go=%b, expected bpos=%h ps=%b cs=%b pp=%0d cp=%0d go=%b",
                 e.name, cyc, BPosition, PScore, CScore, PPoints, CPoints, GameOver,
                 e.bpos, e.ps, e.cs, e.pp, e.cp, e.go);
      end
    end
  end

  task automatic do_reset(output int t);
    Reset = 1'b1;
    @(posedge clkB);
    #1;
    Reset = 1'b0;
    t = cyc;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) begin
      @(posedge clkB);
      #1;
    end
  endtask

  initial begin
    int t0, t1, t2, t3, s, tr;
    logic [23:0] miss_pos;
    Reset     = 1'b1;
    PPosition = 24'h0;
    CPosition = 24'h0;

    // Full game with paddles out of reach: nine right-side misses alternate dy.
    do_reset(t0);
    expect_at(t0,      "reset_state",      C,           0, 0, 0, 0, 0);
    expect_at(t0 + 60, "serve_hold_last",  C,           0, 0, 0, 0, 0);
    expect_at(t0 + 61, "serve_first_step", 24'h12B1D0,  0, 0, 0, 0, 0);
    s = t0 + 60;
    expect_at(s + 125, "top_reach",        24'h0AF24C,  0, 0, 0, 0, 0);
    expect_at(s + 126, "top_bounce",       24'h0B024D,  0, 0, 0, 0, 0);
    expect_at(s + 316, "right_edge_pre",   24'h16E30B,  0, 0, 0, 0, 0);
    for (int r = 0; r < 9; r++) begin
      tr = t0 + 378 * r;
      miss_pos = (r % 2 == 1) ? 24'h0E430B : 24'h16E30B;
      if (r == 1) begin
        expect_at(tr + 182, "bottom_reach",  24'h1A6249, 0, 0, 4'd1, 0, 0);
        expect_at(tr + 183, "bottom_bounce", 24'h1A524A, 0, 0, 4'd1, 0, 0);
      end
      expect_at(tr + 377, "pscore_pulse", miss_pos, 1, 0, 4'(r + 1), 0, 0);
      expect_at(tr + 378, "pscore_clear", C,        0, 0, 4'(r + 1), 0, (r == 8));
    end
    expect_at(t0 + 3500, "over_hold", C, 0, 0, 4'd9, 0, 1);
    wait_to(t0 + 3501);

    // Reset out of OVER, then a computer-paddle bounce and a player-paddle bounce.
    do_reset(t1);
    CPosition = 24'h0BE26D;
    PPosition = 24'h136128;
    expect_at(t1,      "reset_from_over",  C,          0, 0, 0, 0, 0);
    expect_at(t1 + 61, "reserve_step",     24'h12B1D0, 0, 0, 0, 0, 0);
    s = t1 + 60;
    expect_at(s + 154, "cpaddle_pre",      24'h0CC269, 0, 0, 0, 0, 0);
    expect_at(s + 155, "cpaddle_bounce",   24'h0CD268, 0, 0, 0, 0, 0);
    expect_at(s + 373, "bottom_leftward",  24'h1A518E, 0, 0, 0, 0, 0);
    expect_at(s + 471, "ppaddle_pre",      24'h14312C, 0, 0, 0, 0, 0);
    expect_at(s + 472, "ppaddle_bounce",   24'h14212D, 0, 0, 0, 0, 0);
    wait_to(s + 480);

    // Corner: top wall and player paddle on the same tick.
    do_reset(t2);
    CPosition = 24'h0BE26D;
    PPosition = 24'h0AF094;
    s = t2 + 60;
    expect_at(s + 619, "corner_pre",       24'h0AF098, 0, 0, 0, 0, 0);
    expect_at(s + 620, "corner_bounce",    24'h0B0099, 0, 0, 0, 0, 0);
    wait_to(s + 625);

    // Player miss: CScore pulse, CPoints, then a leftward serve.
    do_reset(t3);
    CPosition = 24'h0BE26D;
    PPosition = 24'h000000;
    s = t3 + 60;
    expect_at(s + 620, "top_no_paddle",    24'h0B0097, 0, 0, 0, 0,    0);
    expect_at(s + 627, "left_edge_pre",    24'h0B7090, 0, 0, 0, 0,    0);
    expect_at(s + 628, "cscore_pulse",     24'h0B7090, 0, 1, 0, 4'd1, 0);
    expect_at(s + 629, "cscore_clear",     C,          0, 0, 0, 4'd1, 0);
    expect_at(s + 689, "serve2_hold_last", C,          0, 0, 0, 4'd1, 0);
    expect_at(s + 690, "serve2_leftward",  24'h12D1CE, 0, 0, 0, 4'd1, 0);
    wait_to(s + 700);

    while (sb_q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL %s: never checked, due cyc %0d, now cyc %0d", sb_q[0].name, sb_q[0].cyc, cyc);
      void'(sb_q.pop_front());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
